// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit holding the architectural
// HI/LO registers. Executes MULT, MULTU, DIV, DIVU (32 iterations each) and
// MTHI/MTLO (single-edge register writes).
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous active-high reset
//   start  in   1   request, sampled only while idle
//   funct  in   6   24 mult, 25 multu, 26 div, 27 divu, 17 mthi, 19 mtlo
//   op1    in  32   rs value (multiplicand / dividend / MTxx source)
//   op2    in  32   rt value (multiplier / divisor)
//   busy   out  1   iterative operation in flight
//   done   out  1   one-cycle pulse, HI/LO hold the new result
//   hi     out 32   HI register
//   lo     out 32   LO register
//
// Optional feature: define MDU_SINGLE_CYCLE_MULT_EN to compute mult/multu with
// a full multiplier (result one edge after acceptance, busy never asserted).
// Divide stays iterative in both builds.

module mult_div_unit #(
    parameter int unsigned ITER_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SMUL
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       acc_q, acc_d;      // mult: {partial, multiplier}; div: {rem, quotient}
    logic [31:0]       b_q, b_d;          // multiplicand or divisor magnitude
    logic [31:0]       op1_q, op1_d;      // raw dividend for divide-by-zero HI
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;      // negate product / quotient
    logic              rem_neg_q, rem_neg_d;
    logic              div0_q, div0_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Operand magnitudes for the signed forms
    logic        signed_op;
    logic [31:0] op1_mag, op2_mag;
    assign signed_op = (funct == F_MULT) || (funct == F_DIV);
    assign op1_mag   = (signed_op && op1[31]) ? (~op1 + 32'd1) : op1;
    assign op2_mag   = (signed_op && op2[31]) ? (~op2 + 32'd1) : op2;

    // One shift-add multiply step: add multiplicand when LSB set, shift right
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // One restoring divide step: shift left, keep the subtraction if it fits
    logic [32:0] div_shift, div_trial;
    logic [63:0] div_next;
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_trial = div_shift - {1'b0, b_q};
    assign div_next  = div_trial[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                     : {div_trial[31:0], acc_q[30:0], 1'b1};

    logic [63:0] iter_next;
    assign iter_next = is_div_q ? div_next : mul_next;

    // Sign fix-up of the final iteration's value
    logic [63:0] mul_res;
    logic [31:0] quo_res, rem_res;
    assign mul_res = neg_q     ? (~iter_next + 64'd1)         : iter_next;
    assign quo_res = neg_q     ? (~iter_next[31:0] + 32'd1)   : iter_next[31:0];
    assign rem_res = rem_neg_q ? (~iter_next[63:32] + 32'd1)  : iter_next[63:32];

`ifdef MDU_SINGLE_CYCLE_MULT_EN
    logic [63:0] smul_raw, smul_res;
    assign smul_raw = 64'(op1_mag) * 64'(op2_mag);
    assign smul_res = (signed_op && (op1[31] ^ op2[31])) ? (~smul_raw + 64'd1) : smul_raw;
`endif

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        op1_d     = op1_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (funct)
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            is_div_d  = (funct == F_DIV) || (funct == F_DIVU);
                            neg_d     = signed_op && (op1[31] ^ op2[31]);
                            rem_neg_d = signed_op && op1[31];
                            div0_d    = (op2 == 32'd0);
                            op1_d     = op1;
                            cnt_d     = '0;
                            state_d   = S_RUN;
                            if ((funct == F_DIV) || (funct == F_DIVU)) begin
                                acc_d = {32'd0, op1_mag};
                                b_d   = op2_mag;
                            end else begin
`ifdef MDU_SINGLE_CYCLE_MULT_EN
                                acc_d   = smul_res;
                                state_d = S_SMUL;
`else
                                acc_d = {32'd0, op2_mag};
                                b_d   = op1_mag;
`endif
                            end
                        end
                        F_MTHI:  hi_d = op1;
                        F_MTLO:  lo_d = op1;
                        default: ;
                    endcase
                end
            end

            S_RUN: begin
                acc_d = iter_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    if (!is_div_q) begin
                        hi_d = mul_res[63:32];
                        lo_d = mul_res[31:0];
                    end else if (div0_q) begin
                        hi_d = op1_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end
                end
            end

            S_SMUL: begin
                // Full-multiplier product was captured on the accepting edge
                hi_d    = acc_q[63:32];
                lo_d    = acc_q[31:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            op1_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            op1_q     <= op1_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit. Inputs change and outputs
// are sampled on the falling edge; the design acts on the rising edge.

module tb_mult_div_unit;

    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;

`ifdef MDU_SINGLE_CYCLE_MULT_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 32;
    localparam int MUL_BUSY = 32;
`endif
    localparam int DIV_LAT  = 32;
    localparam int TIMEOUT  = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] op1, op2;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .funct (funct),
        .op1   (op1),
        .op2   (op2),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Present a request for one rising edge (called and returns on a falling edge)
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        funct = f;
        op1   = a;
        op2   = b;
        @(negedge clk);
        start = 1'b0;
        op1   = 32'hA5A5_A5A5;
        op2   = 32'h5A5A_5A5A;
    endtask

    // Issue and wait for done; lat counts falling edges after the accepting edge
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt, output bit hi_stable);
        logic [31:0] hi0;
        hi0 = hi;
        issue(f, a, b);
        lat = 0;
        busy_cnt = 0;
        hi_stable = 1'b1;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            if (busy === 1'b1) busy_cnt++;
            if (hi !== hi0) hi_stable = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        funct = 6'd0;
        op1   = 32'd0;
        op2   = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_multu_max();
        int lat, bc;
        bit hs;
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, hs);
        n_cmp++; if (lat != MUL_LAT) begin n_err++; $display("FAIL multu_latency: got %0d want %0d", lat, MUL_LAT); end
        n_cmp++; if (bc != MUL_BUSY) begin n_err++; $display("FAIL multu_busy_cycles: got %0d want %0d", bc, MUL_BUSY); end
        n_cmp++; if (!hs) begin n_err++; $display("FAIL multu_hi_held: hi changed before done, want held"); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL multu_busy_at_done: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_signed();
        int lat, bc;
        bit hs;
        run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, lat, bc, hs);
        n_cmp++; if (lat != MUL_LAT) begin n_err++; $display("FAIL mult_latency: got %0d want %0d", lat, MUL_LAT); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_neg_lo: got %h want ffffffeb", lo); end
        @(negedge clk);
        run_op(F_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, lat, bc, hs);
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL mult_negneg_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd30) begin n_err++; $display("FAIL mult_negneg_lo: got %h want 1e", lo); end
        @(negedge clk);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc, hs);
        n_cmp++; if (lat != DIV_LAT) begin n_err++; $display("FAIL div_latency: got %0d want %0d", lat, DIV_LAT); end
        n_cmp++; if (bc != 32) begin n_err++; $display("FAIL div_busy_cycles: got %0d want 32", bc); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
        @(negedge clk);
        run_op(F_DIV, 32'd7, 32'hFFFF_FFFE, lat, bc, hs);
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_negdivisor_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'd1) begin n_err++; $display("FAIL div_negdivisor_hi: got %h want 1", hi); end
    endtask

    task automatic test_div_corners();
        int lat, bc;
        bit hs;
        @(negedge clk);
        run_op(F_DIVU, 32'd7, 32'd0, lat, bc, hs);
        n_cmp++; if (lat != DIV_LAT) begin n_err++; $display("FAIL div0_latency: got %0d want %0d", lat, DIV_LAT); end
        n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        n_cmp++; if (hi !== 32'd7) begin n_err++; $display("FAIL div0_hi: got %h want 7", hi); end
        @(negedge clk);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, hs);
        n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
    endtask

    task automatic test_mtxx_and_busy_ignore();
        bit saw_done, saw_dead;
        int lat;
        @(negedge clk);
        saw_done = 1'b0;
        start = 1'b1; funct = F_MTHI; op1 = 32'h0000_1234; op2 = 32'd0;
        @(negedge clk);
        if (done === 1'b1) saw_done = 1'b1;
        n_cmp++; if (hi !== 32'h0000_1234) begin n_err++; $display("FAIL mthi_value: got %h want 00001234", hi); end
        funct = F_MTLO; op1 = 32'h0000_5678;
        @(negedge clk);
        start = 1'b0;
        if (done === 1'b1) saw_done = 1'b1;
        n_cmp++; if (lo !== 32'h0000_5678) begin n_err++; $display("FAIL mtlo_value: got %h want 00005678", lo); end
        n_cmp++; if (hi !== 32'h0000_1234) begin n_err++; $display("FAIL mtlo_keeps_hi: got %h want 00001234", hi); end
        @(negedge clk);
        if (done === 1'b1) saw_done = 1'b1;
        n_cmp++; if (saw_done) begin n_err++; $display("FAIL mtxx_no_done: got done=1 want 0"); end

        // divu 100/7 with an mthi attempted during RUN
        issue(F_DIVU, 32'd100, 32'd7);
        lat = 0;
        saw_dead = 1'b0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            if (hi === 32'h0000_DEAD) saw_dead = 1'b1;
            start = (lat == 5);
            funct = F_MTHI;
            op1   = 32'h0000_DEAD;
            op2   = 32'd1;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (hi === 32'h0000_DEAD) saw_dead = 1'b1;
        n_cmp++; if (lat != DIV_LAT) begin n_err++; $display("FAIL busy_ignore_latency: got %0d want %0d", lat, DIV_LAT); end
        n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL busy_ignore_lo: got %h want e", lo); end
        n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL busy_ignore_hi: got %h want 2", hi); end
        n_cmp++; if (saw_dead) begin n_err++; $display("FAIL busy_ignore_no_mthi: hi showed dead, want never"); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        bit hs;
        run_op(F_MULTU, 32'd3, 32'd5, lat, bc, hs);
        n_cmp++; if (lat != MUL_LAT) begin n_err++; $display("FAIL b2b_mul_latency: got %0d want %0d", lat, MUL_LAT); end
        n_cmp++; if (bc != MUL_BUSY) begin n_err++; $display("FAIL b2b_mul_busy: got %0d want %0d", bc, MUL_BUSY); end
        n_cmp++; if (lo !== 32'd15) begin n_err++; $display("FAIL b2b_mul_lo: got %h want f", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL b2b_mul_hi: got %h want 0", hi); end
        // new start in the done cycle
        run_op(F_DIVU, 32'd100, 32'd7, lat, bc, hs);
        n_cmp++; if (lat != DIV_LAT) begin n_err++; $display("FAIL b2b_div_latency: got %0d want %0d", lat, DIV_LAT); end
        n_cmp++; if (bc != 32) begin n_err++; $display("FAIL b2b_div_busy: got %0d want 32", bc); end
        n_cmp++; if (lo !== 32'd14) begin n_err++; $display("FAIL b2b_div_lo: got %h want e", lo); end
        n_cmp++; if (hi !== 32'd2) begin n_err++; $display("FAIL b2b_div_hi: got %h want 2", hi); end
    endtask

    task automatic test_reset_in_run();
        bit saw_done;
        @(negedge clk);
`ifdef MDU_SINGLE_CYCLE_MULT_EN
        issue(F_DIV, 32'd1000, 32'd3);
`else
        issue(F_MULT, 32'd1000, 32'd3);
`endif
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_run_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL rst_run_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_err++; $display("FAIL rst_run_lo: got %h want 0", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_run_busy: got %b want 0", busy); end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (saw_done) begin n_err++; $display("FAIL rst_run_no_done: got done=1 want none"); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        funct = 6'd0;
        op1   = 32'd0;
        op2   = 32'd0;
        @(negedge clk);
        test_reset();
        test_multu_max();
        test_signed();
        test_div_corners();
        test_mtxx_and_busy_ignore();
        test_back_to_back();
        test_reset_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS core. It sits in the execute stage beside the combinational ALU. It takes the same rs/rt operand values and the instruction `funct` field, and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It exposes HI/LO continuously for MFHI/MFLO. Control logic must stall issue while `busy` is high.

## Interface
Parameters:
- `ITER_CYCLES`, default 32: iterations per iterative operation; fixed at 32 for 32-bit operands, any other value is unsupported.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only while idle (`busy`=0).
- `funct`  in  6  instruction[5:0]: 24 mult, 25 multu, 26 div, 27 divu, 17 mthi, 19 mtlo; other codes are ignored.
- `op1`  in  32  rs value (multiplicand/dividend/MTxx source).
- `op2`  in  32  rt value (multiplier/divisor).
- `busy`  out  1  high while an iterative operation is in flight.
- `done`  out  1  one-cycle pulse: HI/LO now hold the new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM in IDLE, iteration counter 0.
- FSM states:
  - IDLE
    - `start` with funct 24–27 latches op1, op2 and funct into internal registers, goes to RUN, counter=0.
    - `start` with funct 17 writes `hi`=op1; funct 19 writes `lo`=op1. Neither changes state or asserts `done`.
    - `start` with any other funct is ignored.
  - RUN
    - One iteration per cycle; counter increments.
    - On the edge completing iteration 31 (counter==31): write `hi`/`lo`, set `done`=1, return to IDLE.
- Multiply: radix-2 shift-add on 32-bit unsigned magnitudes into a 64-bit product. `hi`=product[63:32], `lo`=product[31:0].
  - mult: operands are sign-magnitude converted; the product is negated (two's complement, 64-bit) when operand signs differ.
  - multu: raw operands.
- Divide: restoring divide on unsigned magnitudes. `lo`=quotient, `hi`=remainder.
  - div: truncates toward zero. The quotient is negated when signs differ; the remainder takes the dividend's sign.
  - div 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Divide by zero (div or divu, op2==0): `lo`=0xFFFFFFFF, `hi`=op1. Same 32-cycle timing.
- Operand inputs are don't-care after the accepting edge; only the latched copies are used.
- `hi`/`lo` hold their previous values throughout RUN. Partial results live in internal registers only.
- `start` while `busy`=1 is ignored: no restart and no MTxx write.
- `reset` asserted in RUN abandons the operation and applies reset values on that edge. No `done` follows.

## Timing
- Accepting edge k (IDLE, `start`=1, funct 24–27): `busy`=1 for the cycles after edges k … k+31.
- Edge k+32: `hi`/`lo` update, `done`=1 and `busy`=0 for exactly one cycle.
- A new `start` is accepted at edge k+33, i.e. in the cycle where `done`=1. Back-to-back throughput is one operation per 33 cycles.
- MTHI/MTLO: the value is visible on `hi`/`lo` the cycle after the accepting edge.
- `busy` and `done` are registered outputs with no combinational path from `start`.

## Configuration
- Macro `MDU_SINGLE_CYCLE_MULT_EN`.
- Defined: mult/multu compute the 64-bit product in one cycle with a full multiplier.
  - At accepting edge k: no RUN state, `busy` stays 0, `hi`/`lo` update at edge k+1 with `done`=1 for the cycle after edge k+1.
  - Divide remains iterative.
- Undefined: all four operations use the 32-iteration path described above.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF, start at edge k → `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` pulse after edge k+32, `busy` high 32 cycles.
- mult 0xFFFFFFFD (−3) × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; div 0xFFFFFFF9 (−7) / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- divu 7 / 0 → `lo`=0xFFFFFFFF, `hi`=7; div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- mthi 0x1234 then mtlo 0x5678 on consecutive edges → `hi`=0x1234, `lo`=0x5678, no `done`. Then divu 100/7 with a second start (mthi 0xDEAD) at RUN cycle 5 → `lo`=14, `hi`=2, `hi` never 0xDEAD.
- Start mult, assert `reset` at RUN cycle 10 → next cycle `hi`=`lo`=0, `busy`=0, and no `done` for the following 40 cycles.
- With `MDU_SINGLE_CYCLE_MULT_EN`: multu 3 × 5 at edge k → `lo`=15, `hi`=0, `done` after edge k+1, `busy` never high. divu still completes at k+32.
